// File: rtl/ram_write_arbiter_pkg.sv
// Shared definitions for the data-RAM write-port arbiter.
//   grantState_e : arbiter state encoding (IDLE = core has the port,
//                  FORCE = one-cycle core stall so a starved host can write)
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
package ram_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FORCE = 1'b1
  } grantState_e;

endpackage

// File: rtl/ram_write_arbiter_sat_counter.sv
// Saturating up-counter.
//   gclk   : clock, counts on posedge
//   grst_n : asynchronous active-low clear
//   clr    : synchronous clear (wins over en)
//   en     : count enable; holds at all-ones once reached
//   count  : current value
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                 count <= '0;
    else if (clr)                count <= '0;
    else if (en && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// Arbitrates the single write port of the data RAM between the core
// writeback (priority) and a host/debug loader. A host request that loses
// MAX_WAIT consecutive cycles forces a one-cycle core stall (FORCE) in which
// the host owns the port.
//   Clock, Reset                 : clock, async active-low reset
//   iCoreWe/iCoreAddr/iCoreData  : core writeback request (valid this cycle)
//   iHostReq/iHostAddr/iHostData : host request, held until oHostAck
//   oHostAck                     : one-cycle pulse the cycle after a host write
//   oCoreStall                   : core must hold IP/decode; its write is dropped
//   oRamWe/oRamAddr/oRamData     : RAM write port (combinational, 0 latency)
//   oHostWrites                  : saturating count of completed host writes
module ram_write_arbiter
  import ram_write_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iCoreWe,
  input  logic [ADDR_W-1:0] iCoreAddr,
  input  logic [DATA_W-1:0] iCoreData,
  input  logic              iHostReq,
  input  logic [ADDR_W-1:0] iHostAddr,
  input  logic [DATA_W-1:0] iHostData,
  output logic              oHostAck,
  output logic              oCoreStall,
  output logic              oRamWe,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamData,
  output logic [15:0]       oHostWrites
);

  localparam logic [4:0] MAX_WAIT_C = 5'(MAX_WAIT);

  grantState_e state, nextState;
  logic [3:0]  waitCnt;
  logic        hostLive, hostGrant, waitInc, waitClr, ramWe;

  // The ack cycle belongs to the request just served, never to a new one.
  assign hostLive = iHostReq & ~oHostAck;

  always_comb begin
    nextState = IDLE;
    hostGrant = 1'b0;
    waitInc   = 1'b0;
    waitClr   = 1'b0;
    case (state)
      IDLE: begin
        if (hostLive && !iCoreWe) begin
          hostGrant = 1'b1;
          waitClr   = 1'b1;
        end else if (hostLive && iCoreWe) begin
          waitInc = 1'b1;
          if (({1'b0, waitCnt} + 5'd1) == MAX_WAIT_C) nextState = FORCE;
        end
      end
      FORCE: begin
        // Host dropping its request here is a protocol violation: the stall
        // still happens but nothing is written or acked.
        hostGrant = iHostReq;
        waitClr   = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      oHostAck <= 1'b0;
    end else begin
      state    <= nextState;
      oHostAck <= hostGrant;
    end
  end

  // Stall comes straight from the state flop so the core sees it early.
  assign oCoreStall = (state == FORCE);

  // In FORCE the core write is ignored; in IDLE a host grant implies !iCoreWe.
  assign ramWe    = hostGrant | ((state == IDLE) & iCoreWe);
  assign oRamWe   = Reset & ramWe;
  assign oRamAddr = !Reset ? '0 : (hostGrant ? iHostAddr : iCoreAddr);
  assign oRamData = !Reset ? '0 : (hostGrant ? iHostData : iCoreData);

  sat_counter #(.WIDTH(4)) uWaitCnt (
    .gclk   (Clock),
    .grst_n (Reset),
    .clr    (waitClr),
    .en     (waitInc),
    .count  (waitCnt)
  );

  sat_counter #(.WIDTH(16)) uHostCnt (
    .gclk   (Clock),
    .grst_n (Reset),
    .clr    (1'b0),
    .en     (hostGrant),
    .count  (oHostWrites)
  );

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              iCoreWe = 1'b0;
  logic [ADDR_W-1:0] iCoreAddr = '0;
  logic [DATA_W-1:0] iCoreData = '0;
  logic              iHostReq = 1'b0;
  logic [ADDR_W-1:0] iHostAddr = '0;
  logic [DATA_W-1:0] iHostData = '0;
  logic              oHostAck, oCoreStall, oRamWe;
  logic [ADDR_W-1:0] oRamAddr;
  logic [DATA_W-1:0] oRamData;
  logic [15:0]       oHostWrites;

  int nChecks = 0;
  int nPass   = 0;

  ram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCoreWe(iCoreWe), .iCoreAddr(iCoreAddr), .iCoreData(iCoreData),
    .iHostReq(iHostReq), .iHostAddr(iHostAddr), .iHostData(iHostData),
    .oHostAck(oHostAck), .oCoreStall(oCoreStall),
    .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamData(oRamData),
    .oHostWrites(oHostWrites)
  );

  always #5 Clock = ~Clock;

  // Behavioural reference: ack pending, consecutive lost cycles, whether this
  // cycle is a forced host slot, and the host write count.
  bit              mAck, mForce;
  int              mLost, mHostCnt;
  bit              eWe, eHostWr, eStall;
  logic [ADDR_W-1:0] eAddr;
  logic [DATA_W-1:0] eData;

  task automatic model_reset();
    mAck = 0; mForce = 0; mLost = 0; mHostCnt = 0;
  endtask

  task automatic model_comb();
    eStall  = mForce;
    eHostWr = mForce ? iHostReq : (iHostReq && !mAck && !iCoreWe);
    eWe     = eHostWr || (!mForce && iCoreWe);
    eAddr   = eHostWr ? iHostAddr : iCoreAddr;
    eData   = eHostWr ? iHostData : iCoreData;
  endtask

  task automatic model_seq();
    if (mForce) begin
      mForce = 0; mLost = 0;
    end else if (iHostReq && !mAck) begin
      if (iCoreWe) begin
        mLost++;
        if (mLost >= MAX_WAIT) mForce = 1;
      end else mLost = 0;
    end
    if (eHostWr) mHostCnt = (mHostCnt >= 65535) ? 65535 : mHostCnt + 1;
    mAck = eHostWr;
  endtask

  task automatic settle();
    model_comb();
    @(negedge Clock);
  endtask

  task automatic tick();
    @(posedge Clock);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    Reset = 0; iCoreWe = 1; iCoreAddr = 8'h05; iCoreData = 16'h0007;
    iHostReq = 1; iHostAddr = 8'h44; iHostData = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      nChecks++;
      if ({oRamWe, oRamAddr, oRamData, oHostAck, oCoreStall, oHostWrites} !== '0)
        $display("FAIL reset_outputs cyc%0d got we=%b a=%h d=%h ack=%b st=%b hw=%h want all 0",
                 i, oRamWe, oRamAddr, oRamData, oHostAck, oCoreStall, oHostWrites);
      else nPass++;
      @(posedge Clock); #1;
    end
    Reset = 1; iHostReq = 0;
    model_reset();
    settle();
    nChecks++;
    if ({oRamWe, oRamAddr, oRamData} !== {1'b1, 8'h05, 16'h0007})
      $display("FAIL reset_release got we=%b a=%h d=%h want 1/05/0007", oRamWe, oRamAddr, oRamData);
    else nPass++;
    tick();
  endtask

  task automatic test_idle_host();
    iCoreWe = 0; iHostReq = 1; iHostAddr = 8'h10; iHostData = 16'hBEEF;
    settle();
    nChecks++;
    if ({oRamWe, oRamAddr, oRamData, oHostAck} !== {1'b1, 8'h10, 16'hBEEF, 1'b0})
      $display("FAIL idle_write got we=%b a=%h d=%h ack=%b want 1/10/BEEF/0", oRamWe, oRamAddr, oRamData, oHostAck);
    else nPass++;
    tick();
    iHostReq = 0;
    settle();
    nChecks++;
    if ({oHostAck, oRamWe, oHostWrites} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL idle_ack got ack=%b we=%b hw=%0d want 1/0/1", oHostAck, oRamWe, oHostWrites);
    else nPass++;
    tick();
    settle();
    nChecks++;
    if (oHostAck !== 1'b0) $display("FAIL idle_ack_pulse got ack=%b want 0", oHostAck);
    else nPass++;
    tick();
  endtask

  task automatic test_starvation();
    iCoreWe = 1; iCoreAddr = 8'h02; iCoreData = 16'h0005;
    iHostReq = 1; iHostAddr = 8'h20; iHostData = 16'h1234;
    for (int i = 0; i < MAX_WAIT; i++) begin
      settle();
      nChecks++;
      if ({oRamWe, oRamAddr, oRamData, oCoreStall} !== {1'b1, 8'h02, 16'h0005, 1'b0})
        $display("FAIL starve_core cyc%0d got we=%b a=%h d=%h st=%b want 1/02/0005/0",
                 i, oRamWe, oRamAddr, oRamData, oCoreStall);
      else nPass++;
      tick();
    end
    settle();
    nChecks++;
    if ({oCoreStall, oRamWe, oRamAddr, oRamData} !== {1'b1, 1'b1, 8'h20, 16'h1234})
      $display("FAIL starve_force got st=%b we=%b a=%h d=%h want 1/1/20/1234",
               oCoreStall, oRamWe, oRamAddr, oRamData);
    else nPass++;
    tick();
    iHostReq = 0;
    settle();
    nChecks++;
    if ({oHostAck, oCoreStall, oRamWe, oRamAddr, oHostWrites} !== {1'b1, 1'b0, 1'b1, 8'h02, 16'd2})
      $display("FAIL starve_resume got ack=%b st=%b we=%b a=%h hw=%0d want 1/0/1/02/2",
               oHostAck, oCoreStall, oRamWe, oRamAddr, oHostWrites);
    else nPass++;
    tick();
  endtask

  task automatic test_back_to_back();
    iCoreWe = 0; iHostReq = 1; iHostAddr = 8'h30; iHostData = 16'hAAAA;
    settle();
    nChecks++;
    if ({oRamWe, oRamAddr} !== {1'b1, 8'h30}) $display("FAIL b2b_first got we=%b a=%h want 1/30", oRamWe, oRamAddr);
    else nPass++;
    tick();
    iHostAddr = 8'h31; iHostData = 16'hBBBB;
    settle();
    nChecks++;
    if ({oHostAck, oRamWe} !== 2'b10) $display("FAIL b2b_ackcycle got ack=%b we=%b want 1/0", oHostAck, oRamWe);
    else nPass++;
    tick();
    settle();
    nChecks++;
    if ({oRamWe, oRamAddr, oRamData} !== {1'b1, 8'h31, 16'hBBBB})
      $display("FAIL b2b_second got we=%b a=%h d=%h want 1/31/BBBB", oRamWe, oRamAddr, oRamData);
    else nPass++;
    tick();
    iHostReq = 0;
    settle();
    nChecks++;
    if ({oHostAck, oHostWrites} !== {1'b1, 16'd4}) $display("FAIL b2b_count got ack=%b hw=%0d want 1/4", oHostAck, oHostWrites);
    else nPass++;
    tick();
  endtask

  task automatic test_dropped();
    iCoreWe = 1; iCoreAddr = 8'h03; iCoreData = 16'h0009;
    iHostReq = 1; iHostAddr = 8'h40; iHostData = 16'h4444;
    for (int i = 0; i < MAX_WAIT; i++) begin settle(); tick(); end
    iHostReq = 0;
    settle();
    nChecks++;
    if ({oCoreStall, oRamWe} !== 2'b10) $display("FAIL drop_stall got st=%b we=%b want 1/0", oCoreStall, oRamWe);
    else nPass++;
    tick();
    settle();
    nChecks++;
    if ({oHostAck, oCoreStall, oRamWe, oHostWrites} !== {1'b0, 1'b0, 1'b1, 16'd4})
      $display("FAIL drop_after got ack=%b st=%b we=%b hw=%0d want 0/0/1/4", oHostAck, oCoreStall, oRamWe, oHostWrites);
    else nPass++;
    tick();
  endtask

  task automatic test_reset_mid();
    iCoreWe = 0; iHostReq = 1; iHostAddr = 8'h50; iHostData = 16'h5050;
    settle(); tick();
    iHostReq = 0; Reset = 0;
    model_reset();
    @(negedge Clock);
    nChecks++;
    if ({oHostAck, oHostWrites} !== 17'd0) $display("FAIL reset_mid got ack=%b hw=%0d want 0/0", oHostAck, oHostWrites);
    else nPass++;
    @(posedge Clock); #1;
    Reset = 1;
  endtask

  task automatic test_saturation();
    force dut.uHostCnt.count = 16'hFFFE;
    #1;
    release dut.uHostCnt.count;
    mHostCnt = 65534;
    iCoreWe = 0;
    for (int w = 0; w < 2; w++) begin
      iHostReq = 1; iHostAddr = 8'h60 + 8'(w); iHostData = 16'h6000;
      settle(); tick();
      iHostReq = 0;
      settle();
      nChecks++;
      if (oHostWrites !== 16'hFFFF) $display("FAIL saturate w%0d got hw=%h want FFFF", w, oHostWrites);
      else nPass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      iCoreWe = ($urandom_range(0, 9) < 7);
      iCoreAddr = 8'($urandom); iCoreData = 16'($urandom);
      if (!iHostReq || mAck) begin
        iHostReq = $urandom_range(0, 1);
        iHostAddr = 8'($urandom); iHostData = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) iHostReq = 0;
      settle();
      nChecks++;
      if (oRamWe !== eWe || oCoreStall !== eStall || oHostAck !== mAck || oHostWrites !== 16'(mHostCnt) ||
          (eWe && (oRamAddr !== eAddr || oRamData !== eData)))
        $display("FAIL random cyc%0d got we=%b a=%h d=%h st=%b ack=%b hw=%0d want we=%b a=%h d=%h st=%b ack=%b hw=%0d",
                 c, oRamWe, oRamAddr, oRamData, oCoreStall, oHostAck, oHostWrites,
                 eWe, eAddr, eData, eStall, mAck, mHostCnt);
      else nPass++;
      tick();
    end
    iHostReq = 0; iCoreWe = 0;
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_idle_host();
    test_starvation();
    test_back_to_back();
    test_dropped();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
